load_store_stage: RTL and testbench

- Parametrised successor to the single-word memory stage; sits between execute and writeback in the in-order pipeline.
- Performs aligned loads and stores over a request/response memory port with byte strobes and lane shifting.
- Supports DATA_WIDTH 32 or 64, with sign/zero extension.
- Traps misaligned or illegal-size accesses instead of issuing them.

---
 rtl/lsu_pkg.sv | 32 +++
 rtl/lsu_lane_align.sv | 61 ++++++
 rtl/load_store_stage.sv | 165 ++++++++++++++++
 tb/tb_load_store_stage.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store stage and its lane aligner.
package lsu_pkg;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_REQ,
    S_RESP,
    S_DONE
  } lsu_state_e;

  typedef enum logic [1:0] {
    BYTE,
    HALF,
    WORD,
    DOUBLE
  } lsu_size_e;

  localparam logic [3:0] EXC_ILLEGAL     = 4'd2;
  localparam logic [3:0] EXC_LD_MISALIGN = 4'd4;
  localparam logic [3:0] EXC_ST_MISALIGN = 4'd6;

  // Address bits that must be zero for a naturally aligned access of this size.
  function automatic logic [2:0] align_mask(lsu_size_e sz);
    case (sz)
      BYTE:    align_mask = 3'b000;
      HALF:    align_mask = 3'b001;
      WORD:    align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store data/strobe placement and load extract with sign/zero extension.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 32,
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  localparam int unsigned OFF_WIDTH  = $clog2(STRB_WIDTH)
) (
  input  lsu_size_e             st_size,
  input  logic [OFF_WIDTH-1:0]  st_off,
  input  logic [DATA_WIDTH-1:0] st_data,
  output logic [DATA_WIDTH-1:0] st_wdata_c,
  output logic [STRB_WIDTH-1:0] st_strb_c,
  input  lsu_size_e             ld_size,
  input  logic                  ld_unsigned,
  input  logic [OFF_WIDTH-1:0]  ld_off,
  input  logic [DATA_WIDTH-1:0] ld_rdata,
  output logic [DATA_WIDTH-1:0] ld_data_c
);

  logic [STRB_WIDTH-1:0] base_strb;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] w_ext;
  logic                  s8;
  logic                  s16;

  always_comb begin
    case (st_size)
      BYTE:    base_strb = STRB_WIDTH'(1);
      HALF:    base_strb = STRB_WIDTH'(3);
      WORD:    base_strb = STRB_WIDTH'(15);
      default: base_strb = '1;
    endcase
  end

  assign st_strb_c  = base_strb << st_off;
  assign st_wdata_c = st_data << {st_off, 3'b000};

  assign shifted = ld_rdata >> {ld_off, 3'b000};
  assign s8      = !ld_unsigned && shifted[7];
  assign s16     = !ld_unsigned && shifted[15];

  // A word only needs extending when the bus is wider than a word.
  if (DATA_WIDTH == 64) begin : g_w64
    logic s32;
    assign s32   = !ld_unsigned && shifted[31];
    assign w_ext = {{32{s32}}, shifted[31:0]};
  end else begin : g_w32
    assign w_ext = shifted;
  end

  always_comb begin
    case (ld_size)
      BYTE:    ld_data_c = {{(DATA_WIDTH-8){s8}}, shifted[7:0]};
      HALF:    ld_data_c = {{(DATA_WIDTH-16){s16}}, shifted[15:0]};
      WORD:    ld_data_c = w_ext;
      default: ld_data_c = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_stage.sv
// Pipeline memory stage: classifies, issues one aligned access at a time, traps bad accesses.
module load_store_stage
  import lsu_pkg::*;
#(
  parameter  int unsigned ADDR_WIDTH    = 32,
  parameter  int unsigned DATA_WIDTH    = 32,
  parameter  int unsigned REG_IDX_WIDTH = 5,
  localparam int unsigned STRB_WIDTH    = DATA_WIDTH / 8,
  localparam int unsigned OFF_WIDTH     = $clog2(STRB_WIDTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     prev_done,
  output logic                     stall_prev,
  output logic                     done_next,
  input  logic                     next_stall,
  input  logic [ADDR_WIDTH-1:0]    pc_in,
  output logic [ADDR_WIDTH-1:0]    pc_out,
  input  logic                     load_in,
  input  logic                     store_in,
  input  logic [2:0]               funct_3_in,
  input  logic [DATA_WIDTH-1:0]    store_data_in,
  input  logic [DATA_WIDTH-1:0]    result_in,
  input  logic [REG_IDX_WIDTH-1:0] rd_in,
  output logic [REG_IDX_WIDTH-1:0] rd_out,
  input  logic                     wb_en_in,
  output logic                     wb_en_out,
  output logic [DATA_WIDTH-1:0]    result_out,
  output logic                     result_valid_out,
  output logic                     exc_valid_out,
  output logic [3:0]               exc_cause_out,
  output logic [REG_IDX_WIDTH-1:0] fwd_rd,
  output logic                     fwd_en,
  output logic                     req_valid,
  input  logic                     req_ready,
  output logic                     req_write,
  output logic [ADDR_WIDTH-1:0]    req_addr,
  output logic [DATA_WIDTH-1:0]    req_wdata,
  output logic [STRB_WIDTH-1:0]    req_strb,
  input  logic                     resp_valid,
  input  logic [DATA_WIDTH-1:0]    resp_rdata
);

  lsu_state_e            state;
  lsu_size_e             in_size;
  lsu_size_e             held_size;
  logic                  held_unsigned;
  logic                  held_load;
  logic [OFF_WIDTH-1:0]  held_off;
  logic [OFF_WIDTH-1:0]  in_off;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic                  capture;
  logic                  is_mem;
  logic                  illegal;
  logic                  misaligned;
  logic [3:0]            cause;
  logic [DATA_WIDTH-1:0] st_wdata;
  logic [STRB_WIDTH-1:0] st_strb;
  logic [DATA_WIDTH-1:0] ld_data;

  // Upstream may hand over in the same cycle a finished result drains downstream.
  assign stall_prev = rst || (state != S_EMPTY && !(state == S_DONE && !next_stall));
  assign capture    = prev_done && !stall_prev;

  assign in_size    = lsu_size_e'(funct_3_in[1:0]);
  assign in_addr    = ADDR_WIDTH'(result_in);
  assign in_off     = in_addr[OFF_WIDTH-1:0];
  assign is_mem     = load_in || store_in;
  assign illegal    = (in_size == DOUBLE && (DATA_WIDTH == 32 || funct_3_in[2]))
                   || (funct_3_in[2] && store_in);
  assign misaligned = |(in_addr[2:0] & align_mask(in_size));
  assign cause      = illegal ? EXC_ILLEGAL : (store_in ? EXC_ST_MISALIGN : EXC_LD_MISALIGN);

  lsu_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .st_size     (in_size),
    .st_off      (in_off),
    .st_data     (store_data_in),
    .st_wdata_c  (st_wdata),
    .st_strb_c   (st_strb),
    .ld_size     (held_size),
    .ld_unsigned (held_unsigned),
    .ld_off      (held_off),
    .ld_rdata    (resp_rdata),
    .ld_data_c   (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_EMPTY;
      done_next        <= 1'b0;
      req_valid        <= 1'b0;
      req_write        <= 1'b0;
      req_addr         <= '0;
      req_wdata        <= '0;
      req_strb         <= '0;
      exc_valid_out    <= 1'b0;
      exc_cause_out    <= '0;
      result_valid_out <= 1'b0;
      result_out       <= '0;
      pc_out           <= '0;
      rd_out           <= '0;
      wb_en_out        <= 1'b0;
      fwd_rd           <= '0;
      fwd_en           <= 1'b0;
      held_size        <= BYTE;
      held_unsigned    <= 1'b0;
      held_load        <= 1'b0;
      held_off         <= '0;
    end else if (capture) begin
      pc_out           <= pc_in;
      rd_out           <= rd_in;
      fwd_rd           <= rd_in;
      wb_en_out        <= wb_en_in;
      fwd_en           <= wb_en_in;
      result_out       <= result_in;
      held_size        <= in_size;
      held_unsigned    <= funct_3_in[2];
      held_load        <= !store_in;
      held_off         <= in_off;
      exc_cause_out    <= '0;
      exc_valid_out    <= 1'b0;
      result_valid_out <= 1'b0;
      if (!is_mem) begin
        state            <= S_DONE;
        done_next        <= 1'b1;
        result_valid_out <= 1'b1;
      end else if (illegal || misaligned) begin
        state         <= S_DONE;
        done_next     <= 1'b1;
        exc_valid_out <= 1'b1;
        exc_cause_out <= cause;
      end else begin
        state     <= S_REQ;
        done_next <= 1'b0;
        req_valid <= 1'b1;
        req_write <= store_in;
        req_addr  <= {in_addr[ADDR_WIDTH-1:OFF_WIDTH], OFF_WIDTH'(0)};
        req_wdata <= st_wdata;
        req_strb  <= st_strb;
      end
    end else begin
      case (state)
        S_REQ: if (req_ready) begin
          state     <= S_RESP;
          req_valid <= 1'b0;
        end
        S_RESP: if (resp_valid) begin
          state            <= S_DONE;
          done_next        <= 1'b1;
          result_valid_out <= held_load;
          if (held_load) result_out <= ld_data;
        end
        S_DONE: if (!next_stall) begin
          state            <= S_EMPTY;
          done_next        <= 1'b0;
          fwd_en           <= 1'b0;
          result_valid_out <= 1'b0;
          exc_valid_out    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_stage.sv
// Directed bench: a 32-bit and a 64-bit stage share stimulus; checks select one instance's outputs.
module tb_load_store_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        prev_done, next_stall, load, store, wb_en, req_ready, resp_valid;
  logic [2:0]  f3;
  logic [63:0] sd, res, rdata;
  logic [31:0] pc;
  logic [4:0]  rd;
  logic        sel;

  logic        a_stall_prev, a_done_next, a_wb_en_out, a_rv, a_exc, a_fwd_en, a_req_valid, a_req_write;
  logic [31:0] a_pc_out, a_result_out, a_req_addr, a_req_wdata;
  logic [4:0]  a_rd_out, a_fwd_rd;
  logic [3:0]  a_cause, a_req_strb;

  logic        b_stall_prev, b_done_next, b_wb_en_out, b_rv, b_exc, b_fwd_en, b_req_valid, b_req_write;
  logic [31:0] b_pc_out, b_req_addr;
  logic [63:0] b_result_out, b_req_wdata;
  logic [4:0]  b_rd_out, b_fwd_rd;
  logic [3:0]  b_cause;
  logic [7:0]  b_req_strb;

  logic        o_stall_prev, o_done_next, o_rv, o_exc, o_fwd_en, o_req_valid, o_req_write;
  logic [31:0] o_pc_out, o_req_addr;
  logic [63:0] o_result_out, o_req_wdata;
  logic [4:0]  o_fwd_rd;
  logic [3:0]  o_cause;
  logic [7:0]  o_req_strb;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  load_store_stage #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .REG_IDX_WIDTH(5)) u_dut32 (
    .clk(clk), .rst(rst), .prev_done(prev_done), .stall_prev(a_stall_prev),
    .done_next(a_done_next), .next_stall(next_stall), .pc_in(pc), .pc_out(a_pc_out),
    .load_in(load), .store_in(store), .funct_3_in(f3), .store_data_in(sd[31:0]),
    .result_in(res[31:0]), .rd_in(rd), .rd_out(a_rd_out), .wb_en_in(wb_en),
    .wb_en_out(a_wb_en_out), .result_out(a_result_out), .result_valid_out(a_rv),
    .exc_valid_out(a_exc), .exc_cause_out(a_cause), .fwd_rd(a_fwd_rd), .fwd_en(a_fwd_en),
    .req_valid(a_req_valid), .req_ready(req_ready), .req_write(a_req_write),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_strb(a_req_strb),
    .resp_valid(resp_valid), .resp_rdata(rdata[31:0])
  );

  load_store_stage #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .REG_IDX_WIDTH(5)) u_dut64 (
    .clk(clk), .rst(rst), .prev_done(prev_done), .stall_prev(b_stall_prev),
    .done_next(b_done_next), .next_stall(next_stall), .pc_in(pc), .pc_out(b_pc_out),
    .load_in(load), .store_in(store), .funct_3_in(f3), .store_data_in(sd),
    .result_in(res), .rd_in(rd), .rd_out(b_rd_out), .wb_en_in(wb_en),
    .wb_en_out(b_wb_en_out), .result_out(b_result_out), .result_valid_out(b_rv),
    .exc_valid_out(b_exc), .exc_cause_out(b_cause), .fwd_rd(b_fwd_rd), .fwd_en(b_fwd_en),
    .req_valid(b_req_valid), .req_ready(req_ready), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_strb(b_req_strb),
    .resp_valid(resp_valid), .resp_rdata(rdata)
  );

  always_comb begin
    o_stall_prev = sel ? b_stall_prev : a_stall_prev;
    o_done_next  = sel ? b_done_next  : a_done_next;
    o_rv         = sel ? b_rv         : a_rv;
    o_exc        = sel ? b_exc        : a_exc;
    o_cause      = sel ? b_cause      : a_cause;
    o_fwd_en     = sel ? b_fwd_en     : a_fwd_en;
    o_fwd_rd     = sel ? b_fwd_rd     : a_fwd_rd;
    o_pc_out     = sel ? b_pc_out     : a_pc_out;
    o_req_valid  = sel ? b_req_valid  : a_req_valid;
    o_req_write  = sel ? b_req_write  : a_req_write;
    o_req_addr   = sel ? b_req_addr   : a_req_addr;
    o_req_wdata  = sel ? b_req_wdata  : {32'd0, a_req_wdata};
    o_req_strb   = sel ? b_req_strb   : {4'd0, a_req_strb};
    o_result_out = sel ? b_result_out : {32'd0, a_result_out};
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic pick(input logic s);
    sel = s;
    #1;
  endtask

  // Presents one instruction for exactly one capture edge.
  task automatic issue(input logic ld, input logic st, input logic [2:0] fn,
                       input logic [63:0] data, input logic [63:0] addr);
    load = ld; store = st; f3 = fn; sd = data; res = addr; prev_done = 1'b1;
    @(posedge clk); #1;
    prev_done = 1'b0; load = 1'b0; store = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Legal access: request accepted at once, response two cycles later.
  task automatic mem_op(input string tag, input logic ld, input logic st, input logic [2:0] fn,
                        input logic [63:0] data, input logic [63:0] addr, input logic [63:0] rword,
                        input logic [31:0] exp_addr, input logic [7:0] exp_strb,
                        input logic [63:0] exp_wdata, input logic [63:0] exp_res);
    issue(ld, st, fn, data, addr);
    check($sformatf("%s.req_valid", tag), 64'(o_req_valid), 64'd1);
    check($sformatf("%s.req_addr", tag), 64'(o_req_addr), 64'(exp_addr));
    check($sformatf("%s.req_strb", tag), 64'(o_req_strb), 64'(exp_strb));
    check($sformatf("%s.req_write", tag), 64'(o_req_write), 64'(st));
    if (st) check($sformatf("%s.req_wdata", tag), o_req_wdata, exp_wdata);
    @(posedge clk); #1;
    check($sformatf("%s.req_drop", tag), 64'(o_req_valid), 64'd0);
    @(posedge clk); #1;
    rdata = rword; resp_valid = 1'b1;
    @(posedge clk); #1;
    resp_valid = 1'b0;
    check($sformatf("%s.done", tag), 64'(o_done_next), 64'd1);
    check($sformatf("%s.rvalid", tag), 64'(o_rv), 64'(ld));
    if (ld) check($sformatf("%s.result", tag), o_result_out, exp_res);
    @(posedge clk); #1;
    check($sformatf("%s.drain", tag), 64'(o_done_next), 64'd0);
  endtask

  task automatic trap(input string tag, input logic ld, input logic st, input logic [2:0] fn,
                      input logic [63:0] addr, input logic [3:0] exp_cause);
    issue(ld, st, fn, 64'h0, addr);
    check($sformatf("%s.no_req", tag), 64'(o_req_valid), 64'd0);
    check($sformatf("%s.done", tag), 64'(o_done_next), 64'd1);
    check($sformatf("%s.exc", tag), 64'(o_exc), 64'd1);
    check($sformatf("%s.cause", tag), 64'(o_cause), 64'(exp_cause));
    check($sformatf("%s.rvalid", tag), 64'(o_rv), 64'd0);
    @(posedge clk); #1;
  endtask

  logic [63:0] vals [4] = '{64'h11, 64'h22, 64'h33, 64'h44};

  initial begin
    rst = 1'b1; prev_done = 1'b0; next_stall = 1'b0; load = 1'b0; store = 1'b0;
    f3 = 3'd0; sd = '0; res = '0; rdata = '0; pc = 32'h0; rd = 5'd0; wb_en = 1'b0;
    req_ready = 1'b1; resp_valid = 1'b0; sel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.done", 64'(o_done_next), 64'd0);
    check("rst.req_valid", 64'(o_req_valid), 64'd0);
    check("rst.exc", 64'(o_exc), 64'd0);
    check("rst.rvalid", 64'(o_rv), 64'd0);
    check("rst.fwd_en", 64'(o_fwd_en), 64'd0);
    check("rst.result", o_result_out, 64'd0);
    check("rst.stall", 64'(o_stall_prev), 64'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    pick(1'b0);
    mem_op("sw",  1'b0, 1'b1, 3'd2, 64'hDEADBEEF, 64'h100, 64'h0, 32'h100, 8'h0F, 64'hDEADBEEF, 64'h0);
    mem_op("lb",  1'b1, 1'b0, 3'd0, 64'h0, 64'h203, 64'h80FFFF00, 32'h200, 8'h08, 64'h0, 64'hFFFFFF80);
    mem_op("lbu", 1'b1, 1'b0, 3'd4, 64'h0, 64'h203, 64'h80FFFF00, 32'h200, 8'h08, 64'h0, 64'h00000080);
    mem_op("sh",  1'b0, 1'b1, 3'd1, 64'h1234, 64'h102, 64'h0, 32'h100, 8'h0C, 64'h12340000, 64'h0);
    mem_op("lh",  1'b1, 1'b0, 3'd1, 64'h0, 64'h102, 64'h80FFFF00, 32'h100, 8'h0C, 64'h0, 64'hFFFF80FF);
    trap("lw_mis", 1'b1, 1'b0, 3'd2, 64'h102, 4'd4);
    trap("sw_mis", 1'b0, 1'b1, 3'd2, 64'h101, 4'd6);
    trap("sbu",    1'b0, 1'b1, 3'd4, 64'h100, 4'd2);
    trap("ld32",   1'b1, 1'b0, 3'd3, 64'h8,   4'd2);
    pulse_rst();

    pick(1'b1);
    mem_op("ld64",  1'b1, 1'b0, 3'd3, 64'h0, 64'h8, 64'h0123456789ABCDEF, 32'h8, 8'hFF, 64'h0, 64'h0123456789ABCDEF);
    mem_op("lwu64", 1'b1, 1'b0, 3'd6, 64'h0, 64'hC, 64'h0123456789ABCDEF, 32'h8, 8'hF0, 64'h0, 64'h0000000001234567);
    mem_op("lw64",  1'b1, 1'b0, 3'd2, 64'h0, 64'hC, 64'hFEDCBA9800000000, 32'h8, 8'hF0, 64'h0, 64'hFFFFFFFFFEDCBA98);
    trap("ldu64", 1'b1, 1'b0, 3'd7, 64'h8, 4'd2);

    // Back-to-back pass-through instructions, then a downstream stall.
    pick(1'b0);
    wb_en = 1'b1; rd = 5'd5; prev_done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      res = vals[i]; pc = 32'h1000 + 32'(i);
      @(posedge clk); #1;
      check($sformatf("add%0d.done", i), 64'(o_done_next), 64'd1);
      check($sformatf("add%0d.result", i), o_result_out, vals[i]);
      check($sformatf("add%0d.pc", i), 64'(o_pc_out), 64'(32'h1000 + 32'(i)));
      check($sformatf("add%0d.stall", i), 64'(o_stall_prev), 64'd0);
    end
    check("add.fwd_en", 64'(o_fwd_en), 64'd1);
    check("add.fwd_rd", 64'(o_fwd_rd), 64'd5);
    res = 64'h55; pc = 32'h2000; next_stall = 1'b1;
    #1;
    check("hold.stall0", 64'(o_stall_prev), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("hold%0d.done", i), 64'(o_done_next), 64'd1);
      check($sformatf("hold%0d.result", i), o_result_out, 64'h44);
      check($sformatf("hold%0d.pc", i), 64'(o_pc_out), 64'h1003);
      check($sformatf("hold%0d.stall", i), 64'(o_stall_prev), 64'd1);
    end
    next_stall = 1'b0;
    @(posedge clk); #1;
    check("release.result", o_result_out, 64'h55);
    prev_done = 1'b0;
    @(posedge clk); #1;
    check("release.drain", 64'(o_done_next), 64'd0);
    check("release.fwd_en", 64'(o_fwd_en), 64'd0);

    // Reset while a load is outstanding; the late response must be ignored.
    issue(1'b1, 1'b0, 3'd2, 64'h0, 64'h100);
    @(posedge clk); #1;
    check("rresp.in_resp", 64'(o_req_valid), 64'd0);
    pulse_rst();
    rdata = 64'hCAFEF00D; resp_valid = 1'b1;
    @(posedge clk); #1;
    resp_valid = 1'b0;
    check("rresp.done", 64'(o_done_next), 64'd0);
    check("rresp.rvalid", 64'(o_rv), 64'd0);
    @(posedge clk); #1;
    check("rresp.done2", 64'(o_done_next), 64'd0);
    check("rresp.empty", 64'(o_stall_prev), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
